mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single-outstanding downstream memory port
// Data wins by default; a waiting fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_data_ok,
  output logic [AW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] d_wdata,
  output logic          d_data_ok,
  output logic [AW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [AW-1:0] m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [AW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     r_state;
  logic       r_gnt_d;
  logic [2:0] r_starve_cnt;

  logic w_pick_i;
  logic w_any_req;
  logic w_issue;
  logic w_done;

  assign w_any_req = i_req | d_req;
  assign w_pick_i  = i_req & (~d_req | (r_starve_cnt == LIMIT));
  assign w_issue   = (r_state == ST_ISSUE) & ~reset;

  // Completion is either a same-cycle accept+response in ISSUE or the response in WAIT;
  // any other m_data_ok is stale and must not reach a requester.
  assign w_done = ~reset & (((r_state == ST_ISSUE) & m_addr_ok & m_data_ok) |
                            ((r_state == ST_WAIT) & m_data_ok));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_gnt_d      <= 1'b0;
      r_starve_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_ISSUE;
            r_gnt_d <= ~w_pick_i;
            if (w_pick_i || !i_req) begin
              r_starve_cnt <= 3'd0;
            end else if (r_starve_cnt != LIMIT) begin
              r_starve_cnt <= r_starve_cnt + 3'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (m_addr_ok) begin
            r_state <= m_data_ok ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_issue) begin
      m_req = 1'b1;
      if (r_gnt_d) begin
        m_wr    = d_wr;
        m_size  = d_size;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        // Fetches are always full-word reads.
        m_size = 2'd2;
        m_addr = i_addr;
      end
    end
  end

  assign i_data_ok = w_done & ~r_gnt_d;
  assign d_data_ok = w_done & r_gnt_d;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Expected completions are queued when requests are driven and popped as data_ok pulses appear.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_data_ok;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  mem_arbiter #(.STARVE_LIMIT(3), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench just after a falling edge, ready to drive the next cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    sb.delete();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [1:0] st;
    exp_t e;
    idle_inputs();
    reset = 1; i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
    tick();
    tick();
    #1;
    st = dut.r_state;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req: got %b want 0", m_req); end
    total++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok: got i=%b d=%b want 0", i_data_ok, d_data_ok); end
    total++; if (dut.r_starve_cnt !== 3'd0) begin bad++; $display("FAIL rst_starve: got %0d want 0", dut.r_starve_cnt); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", st); end
    reset = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 0; i_addr = 32'h0000_1000;
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_no_early_grant: got %b want 0", m_req); end
    sb.push_back('{1'b0, 32'h0000_0055});
    tick();
    #1;
    total++; if (m_req !== 1'b1 || m_addr !== 32'h0000_1000) begin bad++; $display("FAIL rst_first_issue: got req=%b addr=%h want 1/00001000", m_req, m_addr); end
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0000_0055;
    #1;
    if (i_data_ok || d_data_ok) begin
      e = sb.pop_front();
      total++; if (d_data_ok !== e.is_d || i_rdata !== e.rdata) begin bad++; $display("FAIL rst_first_done: got d=%b rdata=%h want d=%b rdata=%h", d_data_ok, i_rdata, e.is_d, e.rdata); end
    end else begin
      total++; bad++; $display("FAIL rst_first_done: got no data_ok want i_data_ok");
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_fetch();
    logic [1:0] st;
    exp_t e;
    apply_reset();
    i_req = 1; i_addr = 32'hBFC0_0000;
    sb.push_back('{1'b0, 32'h2408_0001});
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_idle: got m_req=%b want 0", m_req); end
    tick();
    m_addr_ok = 1;
    #1;
    total++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000 || m_wr !== 1'b0) begin bad++; $display("FAIL fetch_issue: got req=%b addr=%h wr=%b want 1/bfc00000/0", m_req, m_addr, m_wr); end
    tick();
    m_addr_ok = 0;
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      m_data_ok = (c == 1);
      m_rdata   = (c == 1) ? 32'h2408_0001 : 32'hDEAD_BEEF;
      #1;
      total++; if (m_req !== 1'b0) begin bad++; $display("FAIL fetch_wait_mreq: got %b want 0", m_req); end
      if (i_data_ok || d_data_ok) begin
        e = sb.pop_front();
        total++; if (i_data_ok !== !e.is_d || d_data_ok !== e.is_d || i_rdata !== e.rdata) begin bad++; $display("FAIL fetch_done: got i=%b d=%b rdata=%h want i=1 rdata=%h", i_data_ok, d_data_ok, i_rdata, e.rdata); end
      end
      tick();
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL fetch_timeout: got %0d pending want 0", sb.size()); end
    i_req = 0; m_data_ok = 1;
    #1;
    st = dut.r_state;
    total++; if (i_data_ok !== 1'b0) begin bad++; $display("FAIL fetch_single_pulse: got %b want 0", i_data_ok); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL fetch_back_idle: got state %0d want 0", st); end
    tick();
    idle_inputs();
  endtask

  task automatic test_store();
    exp_t e;
    apply_reset();
    d_req = 1; d_wr = 1; d_size = 2'd0; d_addr = 32'h8000_0003; d_wdata = 32'h0000_00AB;
    sb.push_back('{1'b1, 32'h0});
    tick();
    m_addr_ok = 1;
    #1;
    total++; if (m_req !== 1'b1 || m_wr !== 1'b1 || m_size !== 2'd0) begin bad++; $display("FAIL store_ctl: got req=%b wr=%b size=%0d want 1/1/0", m_req, m_wr, m_size); end
    total++; if (m_addr !== 32'h8000_0003 || m_wdata !== 32'h0000_00AB) begin bad++; $display("FAIL store_fields: got addr=%h wdata=%h want 80000003/000000ab", m_addr, m_wdata); end
    total++; if (d_data_ok !== 1'b0) begin bad++; $display("FAIL store_early_ok: got %b want 0", d_data_ok); end
    tick();
    m_addr_ok = 0; m_data_ok = 1;
    #1;
    if (i_data_ok || d_data_ok) begin
      e = sb.pop_front();
      total++; if (d_data_ok !== e.is_d || i_data_ok !== 1'b0) begin bad++; $display("FAIL store_done: got i=%b d=%b want d=1", i_data_ok, d_data_ok); end
    end else begin
      total++; bad++; $display("FAIL store_done: got no data_ok want d_data_ok");
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_contention();
    exp_t e;
    int   last;
    apply_reset();
    i_req = 1; i_addr = 32'h0000_4000;
    d_req = 1; d_addr = 32'h0000_8000; d_size = 2'd2;
    m_addr_ok = 1; m_data_ok = 1;
    for (int k = 0; k < 8; k++) sb.push_back('{(k % 4) != 3, 32'h0});
    last = -1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      m_rdata = 32'hC000_0000 + 32'(c);
      #1;
      total++;
      if (i_data_ok && d_data_ok) begin
        bad++; $display("FAIL cont_both_ok: got i=1 d=1 want at most one");
      end else if (i_data_ok || d_data_ok) begin
        e = sb.pop_front();
        if (d_data_ok !== e.is_d) begin bad++; $display("FAIL cont_order: got d=%b want d=%b (slot %0d)", d_data_ok, e.is_d, 7 - sb.size()); end
        total++; if ((d_data_ok ? d_rdata : i_rdata) !== 32'hC000_0000 + 32'(c)) begin bad++; $display("FAIL cont_rdata: got %h want %h", d_data_ok ? d_rdata : i_rdata, 32'hC000_0000 + 32'(c)); end
        if (last >= 0) begin
          total++; if (c - last != 2) begin bad++; $display("FAIL cont_bubble: got gap %0d want 2", c - last); end
        end
        last = c;
      end
      tick();
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL cont_timeout: got %0d pending want 0", sb.size()); end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    i_req = 1; i_addr = 32'h0000_0040;
    d_req = 1; d_wr = 1; d_size = 2'd1; d_addr = 32'h0000_2000; d_wdata = 32'h0000_1234;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (m_req !== 1'b1 || m_addr !== 32'h0000_2000 || m_wdata !== 32'h0000_1234 || m_size !== 2'd1) begin bad++; $display("FAIL bp_fields: got req=%b addr=%h wdata=%h size=%0d", m_req, m_addr, m_wdata, m_size); end
      total++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin bad++; $display("FAIL bp_no_ok: got i=%b d=%b want 0", i_data_ok, d_data_ok); end
      total++; if (dut.r_starve_cnt !== 3'd1) begin bad++; $display("FAIL bp_starve: got %0d want 1", dut.r_starve_cnt); end
      tick();
    end
    m_addr_ok = 1; m_data_ok = 1;
    #1;
    total++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0) begin bad++; $display("FAIL bp_release: got i=%b d=%b want d=1", i_data_ok, d_data_ok); end
    tick();
    idle_inputs();
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL bp_after: got m_req=%b want 0", m_req); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] st;
    apply_reset();
    d_req = 1; d_addr = 32'h0000_3000;
    tick();
    m_addr_ok = 1;
    tick();
    m_addr_ok = 0;
    #1;
    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rw_wait_mreq: got %b want 0", m_req); end
    tick();
    reset = 1; d_req = 0;
    #1;
    total++; if (m_req !== 1'b0 || d_data_ok !== 1'b0) begin bad++; $display("FAIL rw_in_reset: got req=%b d=%b want 0", m_req, d_data_ok); end
    tick();
    reset = 0; m_data_ok = 1; m_rdata = 32'h1111_2222;
    #1;
    st = dut.r_state;
    total++; if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin bad++; $display("FAIL rw_late_ok: got i=%b d=%b want 0", i_data_ok, d_data_ok); end
    total++; if (st !== 2'd0 || dut.r_starve_cnt !== 3'd0) begin bad++; $display("FAIL rw_state: got state=%0d starve=%0d want 0/0", st, dut.r_starve_cnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    logic [1:0] st;
    exp_t e;
    apply_reset();
    i_req = 1; i_addr = 32'h0000_0800;
    sb.push_back('{1'b0, 32'h0BAD_F00D});
    tick();
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BAD_F00D;
    #1;
    if (i_data_ok || d_data_ok) begin
      e = sb.pop_front();
      total++; if (i_data_ok !== !e.is_d || i_rdata !== e.rdata) begin bad++; $display("FAIL same_done: got i=%b rdata=%h want i=1 rdata=%h", i_data_ok, i_rdata, e.rdata); end
    end else begin
      total++; bad++; $display("FAIL same_done: got no data_ok want i_data_ok at N+1");
    end
    tick();
    i_req = 0; m_addr_ok = 0; m_data_ok = 0;
    #1;
    st = dut.r_state;
    total++; if (st !== 2'd0) begin bad++; $display("FAIL same_no_wait: got state %0d want 0", st); end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
    test_same_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
